// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch/jump flushes and data-memory wait holds.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int unsigned P_LU_BUBBLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_uses_rt,
  input  logic        i_id_jump,
  input  logic        i_ex_mem_read,
  input  logic [4:0]  i_ex_rt,
  input  logic        i_mem_branch_taken,
  input  logic        i_mem_req,
  input  logic        i_dmem_ready,
  output logic        o_pc_write,
  output logic        o_ifid_write,
  output logic        o_if_flush,
  output logic        o_id_flush,
  output logic        o_hazard_to_id,
  output logic        o_ex_flush,
  output logic        o_pipe_hold,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_JUMP
  } action_e;

  localparam logic [1:0] LP_BUB_INIT = 2'(P_LU_BUBBLES - 1);
  localparam bit         LP_MULTI    = (P_LU_BUBBLES > 1);

  state_e     state_q, state_d;
  logic [1:0] bub_cnt_q, bub_cnt_d;
  action_e    action;
  logic       lu_hazard;
  logic       mem_wait;

  assign lu_hazard = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                     ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
  assign mem_wait  = i_mem_req && !i_dmem_ready;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    action    = ACT_NONE;
    if (!i_rst) begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          // A finishing memory wait is re-evaluated exactly like RUN in the same cycle.
          if ((state_q == ST_RUN) ? mem_wait : !i_dmem_ready) begin
            action  = ACT_HOLD;
            state_d = ST_MEM_WAIT;
          end else if (i_mem_branch_taken) begin
            action  = ACT_FLUSH;
            state_d = ST_RUN;
          end else if (lu_hazard) begin
            action    = ACT_BUBBLE;
            bub_cnt_d = LP_BUB_INIT;
            state_d   = LP_MULTI ? ST_LU_STALL : ST_RUN;
          end else if (i_id_jump) begin
            action  = ACT_JUMP;
            state_d = ST_RUN;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_LU_STALL: begin
          if (mem_wait) begin
            action = ACT_HOLD;
          end else if (i_mem_branch_taken) begin
            action    = ACT_FLUSH;
            bub_cnt_d = 2'd0;
            state_d   = ST_RUN;
          end else begin
            action    = ACT_BUBBLE;
            bub_cnt_d = bub_cnt_q - 2'd1;
            if (bub_cnt_q <= 2'd1) state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    o_pc_write     = 1'b1;
    o_ifid_write   = 1'b1;
    o_if_flush     = 1'b0;
    o_id_flush     = 1'b0;
    o_hazard_to_id = 1'b0;
    o_ex_flush     = 1'b0;
    o_pipe_hold    = 1'b0;
    case (action)
      ACT_HOLD: begin
        o_pipe_hold  = 1'b1;
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
      end
      ACT_FLUSH: begin
        o_if_flush = 1'b1;
        o_id_flush = 1'b1;
        o_ex_flush = 1'b1;
      end
      ACT_BUBBLE: begin
        o_hazard_to_id = 1'b1;
        o_pc_write     = 1'b0;
        o_ifid_write   = 1'b0;
      end
      ACT_JUMP: o_if_flush = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_RUN;
      bub_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (o_hazard_to_id) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (o_ex_flush)     flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  // Counters read as zero while reset is held, before the clearing edge arrives.
  assign o_stall_cnt = i_rst ? 32'd0 : stall_cnt_q;
  assign o_flush_cnt = i_rst ? 32'd0 : flush_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: two instances (1 and 3 bubbles) checked via an expected-value queue.
module tb_hazard_unit;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       br;
    logic       mem_req;
    logic       ready;
  } stim_t;

  typedef struct {
    string       tag;
    logic [1:0]  sel;
    logic [6:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  // ctrl order: {pc_write, ifid_write, if_flush, id_flush, hazard_to_id, ex_flush, pipe_hold}
  localparam logic [6:0] C_DEF = 7'b1100000;
  localparam logic [6:0] C_BUB = 7'b0000100;
  localparam logic [6:0] C_HLD = 7'b0000001;
  localparam logic [6:0] C_FLS = 7'b1111010;
  localparam logic [6:0] C_JMP = 7'b1110000;

  logic       clk = 1'b1;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jump, ex_mem_read, br_taken, mem_req, dmem_ready;

  logic        pcw1, ifw1, iff1, idf1, hz1, exf1, ph1;
  logic [31:0] sc1, fc1;
  logic        pcw3, ifw3, iff3, idf3, hz3, exf3, ph3;
  logic [31:0] sc3, fc3;

  exp_t exp_q[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.P_LU_BUBBLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_id_jump(id_jump), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
    .i_mem_branch_taken(br_taken), .i_mem_req(mem_req), .i_dmem_ready(dmem_ready),
    .o_pc_write(pcw1), .o_ifid_write(ifw1), .o_if_flush(iff1), .o_id_flush(idf1),
    .o_hazard_to_id(hz1), .o_ex_flush(exf1), .o_pipe_hold(ph1),
    .o_stall_cnt(sc1), .o_flush_cnt(fc1)
  );

  hazard_unit #(.P_LU_BUBBLES(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_id_jump(id_jump), .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt),
    .i_mem_branch_taken(br_taken), .i_mem_req(mem_req), .i_dmem_ready(dmem_ready),
    .o_pc_write(pcw3), .o_ifid_write(ifw3), .o_if_flush(iff3), .o_id_flush(idf3),
    .o_hazard_to_id(hz3), .o_ex_flush(exf3), .o_pipe_hold(ph3),
    .o_stall_cnt(sc3), .o_flush_cnt(fc3)
  );

  function automatic logic [31:0] cnt(input int n);
`ifdef HAZARD_PERF_EN
    return 32'(n);
`else
    return (n == -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic stim_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic jmp, input logic mr,
                               input logic [4:0] exrt, input logic br, input logic mreq,
                               input logic rdy);
    stim_t s;
    s = {r, rs, rt, urt, jmp, mr, exrt, br, mreq, rdy};
    return s;
  endfunction

  // Scoreboard: pop one expectation per cycle, compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      if (cur.sel != 2'd3) begin
        checks++;
        assert ({pcw1, ifw1, iff1, idf1, hz1, exf1, ph1, sc1, fc1} === {cur.ctrl, cur.stall, cur.flush})
        else begin
          failures++;
          $error("FAIL %s dut1 observed ctrl=%b stall=%0d flush=%0d expected ctrl=%b stall=%0d flush=%0d",
                 cur.tag, {pcw1, ifw1, iff1, idf1, hz1, exf1, ph1}, sc1, fc1,
                 cur.ctrl, cur.stall, cur.flush);
        end
      end
      if (cur.sel != 2'd1) begin
        checks++;
        assert ({pcw3, ifw3, iff3, idf3, hz3, exf3, ph3, sc3, fc3} === {cur.ctrl, cur.stall, cur.flush})
        else begin
          failures++;
          $error("FAIL %s dut3 observed ctrl=%b stall=%0d flush=%0d expected ctrl=%b stall=%0d flush=%0d",
                 cur.tag, {pcw3, ifw3, iff3, idf3, hz3, exf3, ph3}, sc3, fc3,
                 cur.ctrl, cur.stall, cur.flush);
        end
      end
    end
  end

  task automatic step(input string tag, input logic [1:0] sel, input stim_t s,
                      input logic [6:0] ctrl, input int stall, input int flush);
    exp_t e;
    {rst, id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt, br_taken, mem_req, dmem_ready} = s;
    e.tag   = tag;
    e.sel   = sel;
    e.ctrl  = ctrl;
    e.stall = cnt(stall);
    e.flush = cnt(flush);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t idle, lu, rst_lu, br, lu_mw, lu_rdy, lu_br;
    idle   = mk(0, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 1);
    lu     = mk(0, 5'd8, 5'd2, 1, 0, 1, 5'd8, 0, 0, 1);
    rst_lu = mk(1, 5'd8, 5'd2, 1, 1, 1, 5'd8, 1, 1, 0);
    br     = mk(0, 5'd1, 5'd2, 1, 0, 0, 5'd0, 1, 0, 1);
    lu_mw  = mk(0, 5'd8, 5'd2, 1, 0, 1, 5'd8, 0, 1, 0);
    lu_rdy = mk(0, 5'd8, 5'd2, 1, 0, 1, 5'd8, 0, 1, 1);
    lu_br  = mk(0, 5'd8, 5'd2, 1, 0, 1, 5'd8, 1, 0, 1);
    #1;

    // Reset held with every hazard input active: RUN defaults only.
    step("reset_hold", 2'd0, rst_lu, C_DEF, 0, 0);

    // Single-bubble instance.
    step("p1_bubble",     2'd1, lu,   C_BUB, 0, 0);
    step("p1_after",      2'd1, idle, C_DEF, 1, 0);
    step("p1_back2back0", 2'd1, lu,   C_BUB, 1, 0);
    step("p1_back2back1", 2'd1, lu,   C_BUB, 2, 0);
    step("p1_done",       2'd1, idle, C_DEF, 3, 0);

    // Three-bubble instance: stall continues even after the load leaves EX.
    step("reset2",   2'd0, rst_lu, C_DEF, 0, 0);
    step("p3_bub1",  2'd3, lu,     C_BUB, 0, 0);
    step("p3_bub2",  2'd3, idle,   C_BUB, 1, 0);
    step("p3_bub3",  2'd3, idle,   C_BUB, 2, 0);
    step("p3_run",   2'd3, idle,   C_DEF, 3, 0);

    // Register zero never hazards; rt only hazards when the instruction reads rt.
    step("rt_zero",    2'd3, mk(0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 1), C_DEF, 3, 0);
    step("rt_unused",  2'd3, mk(0, 5'd3, 5'd8, 0, 0, 1, 5'd8, 0, 0, 1), C_DEF, 3, 0);
    step("rt_used",    2'd3, mk(0, 5'd3, 5'd8, 1, 0, 1, 5'd8, 0, 0, 1), C_BUB, 3, 0);
    step("rt_bub2",    2'd3, idle, C_BUB, 4, 0);
    step("rt_bub3",    2'd3, idle, C_BUB, 5, 0);
    step("rt_run",     2'd3, idle, C_DEF, 6, 0);
    step("jump_only",  2'd3, mk(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 1), C_JMP, 6, 0);
    step("jump_lu",    2'd3, mk(0, 5'd8, 5'd2, 1, 1, 1, 5'd8, 0, 0, 1), C_BUB, 6, 0);

    // Branch taken in the second bubble cancels the rest of the stall.
    step("reset3",     2'd0, rst_lu, C_DEF, 0, 0);
    step("br_bub1",    2'd3, lu,     C_BUB, 0, 0);
    step("br_flush",   2'd3, br,     C_FLS, 1, 0);
    step("br_after",   2'd3, idle,   C_DEF, 1, 1);
    step("br_over_lu", 2'd3, lu_br,  C_FLS, 1, 1);
    step("br_after2",  2'd3, idle,   C_DEF, 1, 2);

    // Memory wait outranks the load-use bubble and freezes the bubble count.
    step("reset4",    2'd0, rst_lu, C_DEF, 0, 0);
    step("mw_hold1",  2'd3, lu_mw,  C_HLD, 0, 0);
    step("mw_hold2",  2'd3, lu_mw,  C_HLD, 0, 0);
    step("mw_hold3",  2'd3, lu_mw,  C_HLD, 0, 0);
    step("mw_hold4",  2'd3, lu_mw,  C_HLD, 0, 0);
    step("mw_ready",  2'd3, lu_rdy, C_BUB, 0, 0);
    step("mw_frz1",   2'd3, lu_mw,  C_HLD, 1, 0);
    step("mw_frz2",   2'd3, lu_mw,  C_HLD, 1, 0);
    step("mw_bub2",   2'd3, idle,   C_BUB, 1, 0);
    step("mw_bub3",   2'd3, idle,   C_BUB, 2, 0);
    step("mw_run",    2'd3, idle,   C_DEF, 3, 0);

    // Reset in the middle of a stall.
    step("reset5",    2'd0, rst_lu, C_DEF, 0, 0);
    step("mid_bub1",  2'd3, lu,     C_BUB, 0, 0);
    step("mid_bub2",  2'd3, idle,   C_BUB, 1, 0);
    step("mid_rst",   2'd0, rst_lu, C_DEF, 0, 0);
    step("post_rst",  2'd3, idle,   C_DEF, 0, 0);
    step("post_lu",   2'd3, lu,     C_BUB, 0, 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
